// File: rtl/id_stage_pipelined.sv
// Decode stage: register file, operand/immediate decode, load-use detection and the ID/EX register.
// One cycle from IF/ID to ID/EX; Stall (hazard or Hold) is combinational and Hold freezes ID/EX.
module id_stage_pipelined #(
    parameter int NBits     = 32,
    parameter int CtrlBits  = 12,
    parameter int WB_BYPASS = 1,
    parameter int LINK_REG  = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NBits-1:0]    IfId_Instruction,
    input  logic [NBits-1:0]    IfId_PC4,
    input  logic                IfId_Valid,
    input  logic [CtrlBits-1:0] CtrlBundle,
    input  logic                RegDst,
    input  logic                Link,
    input  logic                RegWrite,
    input  logic                MemRead,
    input  logic                ZeroExtend,
    input  logic                UsesRt,
    input  logic                WB_RegWrite,
    input  logic [4:0]          WB_WriteRegister,
    input  logic [NBits-1:0]    WB_WriteData,
    input  logic                Flush,
    input  logic                Hold,
    output logic                Stall,
    output logic                IdEx_Valid,
    output logic [CtrlBits-1:0] IdEx_Ctrl,
    output logic                IdEx_RegWrite,
    output logic                IdEx_MemRead,
    output logic [NBits-1:0]    IdEx_ReadData1,
    output logic [NBits-1:0]    IdEx_ReadData2,
    output logic [NBits-1:0]    IdEx_Immediate,
    output logic [NBits-1:0]    IdEx_Shamt,
    output logic [4:0]          IdEx_WriteRegister,
    output logic [4:0]          IdEx_Rs,
    output logic [4:0]          IdEx_Rt,
    output logic [NBits-1:0]    IdEx_PC4
);
    localparam logic [4:0] LinkAddr = 5'(LINK_REG);

    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        unused_instr_hi;

    assign rs    = IfId_Instruction[25:21];
    assign rt    = IfId_Instruction[20:16];
    assign rd    = IfId_Instruction[15:11];
    assign imm16 = IfId_Instruction[15:0];
    assign unused_instr_hi = ^IfId_Instruction[NBits-1:26];

    logic [NBits-1:0] regs_q [32];
    logic [NBits-1:0] regs_d [32];

    logic [NBits-1:0]    rdata1, rdata2, imm_ext, shamt_ext;
    logic [4:0]          dest;
    logic                hazard;
    logic                wb_active;

    logic                valid_q, valid_d;
    logic [CtrlBits-1:0] ctrl_q, ctrl_d;
    logic                regwrite_q, regwrite_d;
    logic                memread_q, memread_d;
    logic [NBits-1:0]    rdata1_q, rdata1_d;
    logic [NBits-1:0]    rdata2_q, rdata2_d;
    logic [NBits-1:0]    imm_q, imm_d;
    logic [NBits-1:0]    shamt_q, shamt_d;
    logic [4:0]          wreg_q, wreg_d;
    logic [4:0]          rs_q, rs_d;
    logic [4:0]          rt_q, rt_d;
    logic [NBits-1:0]    pc4_q, pc4_d;

    assign wb_active = WB_RegWrite && (WB_WriteRegister != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wb_active) begin
            regs_d[WB_WriteRegister] = WB_WriteData;
        end
    end

    // Register 0 is hardwired; bypass only applies to nonzero write addresses.
    always_comb begin
        rdata1 = regs_q[rs];
        rdata2 = regs_q[rt];
        if (rs == 5'd0) begin
            rdata1 = '0;
        end else if ((WB_BYPASS != 0) && wb_active && (WB_WriteRegister == rs)) begin
            rdata1 = WB_WriteData;
        end
        if (rt == 5'd0) begin
            rdata2 = '0;
        end else if ((WB_BYPASS != 0) && wb_active && (WB_WriteRegister == rt)) begin
            rdata2 = WB_WriteData;
        end
    end

    always_comb begin
        dest      = Link ? LinkAddr : (RegDst ? rd : rt);
        imm_ext   = ZeroExtend ? {{(NBits-16){1'b0}}, imm16} : {{(NBits-16){imm16[15]}}, imm16};
        shamt_ext = {{(NBits-5){1'b0}}, IfId_Instruction[10:6]};
    end

    assign hazard = valid_q && memread_q && (wreg_q != 5'd0) && IfId_Valid &&
                    ((wreg_q == rs) || (UsesRt && (wreg_q == rt)));

    assign Stall = !reset && (hazard || Hold);

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        wreg_d     = wreg_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        pc4_d      = pc4_q;
        if (!Hold) begin
            rdata1_d = rdata1;
            rdata2_d = rdata2;
            imm_d    = imm_ext;
            shamt_d  = shamt_ext;
            wreg_d   = dest;
            rs_d     = rs;
            rt_d     = rt;
            pc4_d    = IfId_PC4;
            // A bubble still loads the data fields; only the qualifiers are cleared.
            if (Flush || hazard) begin
                valid_d    = 1'b0;
                ctrl_d     = '0;
                regwrite_d = 1'b0;
                memread_d  = 1'b0;
            end else begin
                valid_d    = IfId_Valid;
                ctrl_d     = CtrlBundle;
                regwrite_d = RegWrite && IfId_Valid;
                memread_d  = MemRead && IfId_Valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            wreg_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            pc4_q      <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            wreg_q     <= wreg_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            pc4_q      <= pc4_d;
        end
    end

    assign IdEx_Valid         = valid_q;
    assign IdEx_Ctrl          = ctrl_q;
    assign IdEx_RegWrite      = regwrite_q;
    assign IdEx_MemRead       = memread_q;
    assign IdEx_ReadData1     = rdata1_q;
    assign IdEx_ReadData2     = rdata2_q;
    assign IdEx_Immediate     = imm_q;
    assign IdEx_Shamt         = shamt_q;
    assign IdEx_WriteRegister = wreg_q;
    assign IdEx_Rs            = rs_q;
    assign IdEx_Rt            = rt_q;
    assign IdEx_PC4           = pc4_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined; a second instance without write-back bypass shares the inputs.
module tb_id_stage_pipelined;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] instr, pc4;
    logic        ifid_valid;
    logic [11:0] ctrl;
    logic        regdst, link, regwrite, memread, zext, usesrt;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush, hold;

    logic        b_stall, b_valid, b_regwrite, b_memread;
    logic [11:0] b_ctrl;
    logic [31:0] b_rd1, b_rd2, b_imm, b_shamt, b_pc4;
    logic [4:0]  b_wreg, b_rs, b_rt;

    logic        n_stall, n_valid, n_regwrite, n_memread;
    logic [11:0] n_ctrl;
    logic [31:0] n_rd1, n_rd2, n_imm, n_shamt, n_pc4;
    logic [4:0]  n_wreg, n_rs, n_rt;

    id_stage_pipelined #(.NBits(32), .CtrlBits(12), .WB_BYPASS(1), .LINK_REG(31)) dut (
        .clk(clk), .reset(reset), .IfId_Instruction(instr), .IfId_PC4(pc4), .IfId_Valid(ifid_valid),
        .CtrlBundle(ctrl), .RegDst(regdst), .Link(link), .RegWrite(regwrite), .MemRead(memread),
        .ZeroExtend(zext), .UsesRt(usesrt), .WB_RegWrite(wb_we), .WB_WriteRegister(wb_addr),
        .WB_WriteData(wb_data), .Flush(flush), .Hold(hold), .Stall(b_stall), .IdEx_Valid(b_valid),
        .IdEx_Ctrl(b_ctrl), .IdEx_RegWrite(b_regwrite), .IdEx_MemRead(b_memread),
        .IdEx_ReadData1(b_rd1), .IdEx_ReadData2(b_rd2), .IdEx_Immediate(b_imm), .IdEx_Shamt(b_shamt),
        .IdEx_WriteRegister(b_wreg), .IdEx_Rs(b_rs), .IdEx_Rt(b_rt), .IdEx_PC4(b_pc4)
    );

    id_stage_pipelined #(.NBits(32), .CtrlBits(12), .WB_BYPASS(0), .LINK_REG(31)) dut_nb (
        .clk(clk), .reset(reset), .IfId_Instruction(instr), .IfId_PC4(pc4), .IfId_Valid(ifid_valid),
        .CtrlBundle(ctrl), .RegDst(regdst), .Link(link), .RegWrite(regwrite), .MemRead(memread),
        .ZeroExtend(zext), .UsesRt(usesrt), .WB_RegWrite(wb_we), .WB_WriteRegister(wb_addr),
        .WB_WriteData(wb_data), .Flush(flush), .Hold(hold), .Stall(n_stall), .IdEx_Valid(n_valid),
        .IdEx_Ctrl(n_ctrl), .IdEx_RegWrite(n_regwrite), .IdEx_MemRead(n_memread),
        .IdEx_ReadData1(n_rd1), .IdEx_ReadData2(n_rd2), .IdEx_Immediate(n_imm), .IdEx_Shamt(n_shamt),
        .IdEx_WriteRegister(n_wreg), .IdEx_Rs(n_rs), .IdEx_Rt(n_rt), .IdEx_PC4(n_pc4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic set_id(input logic [31:0] i, input logic [31:0] p, input logic rdst,
                          input logic rw, input logic mr, input logic ur, input logic [11:0] c);
        instr = i; pc4 = p; ifid_valid = 1'b1; regdst = rdst; link = 1'b0;
        regwrite = rw; memread = mr; zext = 1'b0; usesrt = ur; ctrl = c;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_we = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        regdst;
        logic        link;
        logic        zext;
        logic [31:0] exp_imm;
        logic [31:0] exp_shamt;
        logic [4:0]  exp_wreg;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[5];

    initial begin
        // addi $7,$0,-1 / ori $6,$0,0xFFFF / sll $4,$2,31 / same sll invalid / jal
        vecs[0] = '{i_type(6'h08, 5'd0, 5'd7, 16'hFFFF), 32'h100, 1'b1, 1'b0, 1'b0, 1'b0,
                    32'hFFFF_FFFF, 32'd31, 5'd7, 1'b1};
        vecs[1] = '{i_type(6'h0D, 5'd0, 5'd6, 16'hFFFF), 32'h104, 1'b1, 1'b0, 1'b0, 1'b1,
                    32'h0000_FFFF, 32'd31, 5'd6, 1'b1};
        vecs[2] = '{{6'h00, 5'd0, 5'd2, 5'd4, 5'd31, 6'h00}, 32'h108, 1'b1, 1'b1, 1'b0, 1'b0,
                    32'h0000_27C0, 32'd31, 5'd4, 1'b1};
        vecs[3] = '{{6'h00, 5'd0, 5'd2, 5'd4, 5'd31, 6'h00}, 32'h10C, 1'b0, 1'b1, 1'b0, 1'b0,
                    32'h0000_27C0, 32'd31, 5'd4, 1'b0};
        vecs[4] = '{{6'h03, 26'h000_0100}, 32'h404, 1'b1, 1'b0, 1'b1, 1'b0,
                    32'h0000_0100, 32'd4, 5'd31, 1'b1};

        reset = 1'b1; instr = '0; pc4 = '0; ifid_valid = 1'b0; ctrl = '0;
        regdst = 1'b0; link = 1'b0; regwrite = 1'b0; memread = 1'b0; zext = 1'b0; usesrt = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; hold = 1'b0;
        step();
        step();

        // Reset clears registers and the whole ID/EX register
        reset = 1'b0;
        wb_write(5'd5, 32'd7);
        set_id(r_type(5'd5, 5'd0, 5'd9, 5'd0), 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A5);
        step();
        chk("r5_before_reset", b_rd1, 32'd7);
        reset = 1'b1; hold = 1'b1;
        #1 chk("stall_low_in_reset", {31'd0, b_stall}, 32'd0);
        step();
        step();
        chk("rst_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_ctrl", {20'd0, b_ctrl}, 32'd0);
        chk("rst_regwrite", {31'd0, b_regwrite}, 32'd0);
        chk("rst_memread", {31'd0, b_memread}, 32'd0);
        chk("rst_rd1", b_rd1, 32'd0);
        chk("rst_rd2", b_rd2, 32'd0);
        chk("rst_imm", b_imm, 32'd0);
        chk("rst_shamt", b_shamt, 32'd0);
        chk("rst_wreg", {27'd0, b_wreg}, 32'd0);
        chk("rst_rs", {27'd0, b_rs}, 32'd0);
        chk("rst_rt", {27'd0, b_rt}, 32'd0);
        chk("rst_pc4", b_pc4, 32'd0);
        reset = 1'b0; hold = 1'b0;
        step();
        chk("r5_after_reset", b_rd1, 32'd0);

        // add $3,$1,$2
        wb_write(5'd1, 32'd4);
        wb_write(5'd2, 32'd5);
        set_id(r_type(5'd1, 5'd2, 5'd3, 5'd0), 32'h24, 1'b1, 1'b1, 1'b0, 1'b1, 12'hA5A);
        step();
        chk("add_rd1", b_rd1, 32'd4);
        chk("add_rd2", b_rd2, 32'd5);
        chk("add_wreg", {27'd0, b_wreg}, 32'd3);
        chk("add_valid", {31'd0, b_valid}, 32'd1);
        chk("add_regwrite", {31'd0, b_regwrite}, 32'd1);
        chk("add_ctrl", {20'd0, b_ctrl}, 32'hA5A);
        chk("add_rs", {27'd0, b_rs}, 32'd1);
        chk("add_rt", {27'd0, b_rt}, 32'd2);

        // Same-cycle write-back visibility, and register 0
        wb_write(5'd8, 32'h1111);
        set_id(r_type(5'd8, 5'd0, 5'd9, 5'd0), 32'h28, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001);
        wb_write(5'd8, 32'hDEAD);
        chk("bypass_on_r8", b_rd1, 32'hDEAD);
        chk("bypass_off_r8", n_rd1, 32'h1111);
        step();
        chk("bypass_off_r8_next", n_rd1, 32'hDEAD);
        set_id(r_type(5'd0, 5'd0, 5'd9, 5'd0), 32'h2C, 1'b1, 1'b1, 1'b0, 1'b0, 12'h001);
        wb_write(5'd0, 32'h55);
        chk("r0_bypass", b_rd1, 32'd0);
        step();
        chk("r0_stored", b_rd1, 32'd0);
        chk("r0_stored_nb", n_rd1, 32'd0);

        // Load-use on rs: one stall cycle, one bubble, then issue
        set_id(i_type(6'h23, 5'd1, 5'd9, 16'h0), 32'h30, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123);
        #1 chk("lw_no_stall", {31'd0, b_stall}, 32'd0);
        step();
        chk("lw_memread", {31'd0, b_memread}, 32'd1);
        chk("lw_wreg", {27'd0, b_wreg}, 32'd9);
        set_id(r_type(5'd9, 5'd4, 5'd10, 5'd0), 32'h34, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0F0);
        #1 chk("lu_stall", {31'd0, b_stall}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'd0, b_valid}, 32'd0);
        chk("lu_bubble_ctrl", {20'd0, b_ctrl}, 32'd0);
        chk("lu_bubble_regwrite", {31'd0, b_regwrite}, 32'd0);
        chk("lu_bubble_memread", {31'd0, b_memread}, 32'd0);
        chk("lu_stall_released", {31'd0, b_stall}, 32'd0);
        step();
        chk("lu_issue_valid", {31'd0, b_valid}, 32'd1);
        chk("lu_issue_wreg", {27'd0, b_wreg}, 32'd10);
        chk("lu_issue_ctrl", {20'd0, b_ctrl}, 32'h0F0);
        chk("lu_issue_pc4", b_pc4, 32'h34);

        // Load-use on rt depends on UsesRt
        set_id(i_type(6'h23, 5'd1, 5'd9, 16'h0), 32'h38, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123);
        step();
        set_id(r_type(5'd4, 5'd9, 5'd10, 5'd0), 32'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0F0);
        #1 chk("lu_rt_stall", {31'd0, b_stall}, 32'd1);
        usesrt = 1'b0;
        #1 chk("lu_rt_unused_no_stall", {31'd0, b_stall}, 32'd0);
        step();
        chk("lu_rt_unused_issue", {31'd0, b_valid}, 32'd1);

        // Load to $0 never stalls
        set_id(i_type(6'h23, 5'd1, 5'd0, 16'h0), 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123);
        step();
        chk("lw0_memread", {31'd0, b_memread}, 32'd1);
        set_id(r_type(5'd0, 5'd0, 5'd10, 5'd0), 32'h44, 1'b1, 1'b1, 1'b0, 1'b1, 12'h0F0);
        #1 chk("lw0_no_stall", {31'd0, b_stall}, 32'd0);
        step();
        chk("lw0_issue_valid", {31'd0, b_valid}, 32'd1);

        // Immediate, shamt and destination decode
        for (int i = 0; i < 5; i++) begin
            set_id(vecs[i].instr, vecs[i].pc4, vecs[i].regdst, 1'b1, 1'b0, 1'b0, 12'h3C3);
            ifid_valid = vecs[i].valid;
            link = vecs[i].link;
            zext = vecs[i].zext;
            step();
            chk($sformatf("vec%0d_imm", i), b_imm, vecs[i].exp_imm);
            chk($sformatf("vec%0d_shamt", i), b_shamt, vecs[i].exp_shamt);
            chk($sformatf("vec%0d_wreg", i), {27'd0, b_wreg}, {27'd0, vecs[i].exp_wreg});
            chk($sformatf("vec%0d_pc4", i), b_pc4, vecs[i].pc4);
            chk($sformatf("vec%0d_valid", i), {31'd0, b_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_regwrite", i), {31'd0, b_regwrite}, {31'd0, vecs[i].exp_valid});
        end

        // Flush the instruction after jal
        set_id(r_type(5'd1, 5'd2, 5'd11, 5'd0), 32'h408, 1'b1, 1'b1, 1'b0, 1'b0, 12'h7FF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", {31'd0, b_valid}, 32'd0);
        chk("flush_ctrl", {20'd0, b_ctrl}, 32'd0);
        chk("flush_regwrite", {31'd0, b_regwrite}, 32'd0);
        chk("flush_pc4_loaded", b_pc4, 32'h408);

        // Hold freezes ID/EX over a Flush pulse while write-back continues
        set_id(r_type(5'd1, 5'd2, 5'd13, 5'd0), 32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 12'h111);
        step();
        chk("pre_hold_pc4", b_pc4, 32'h500);
        set_id(r_type(5'd12, 5'd2, 5'd14, 5'd0), 32'h504, 1'b1, 1'b1, 1'b0, 1'b0, 12'h222);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            wb_we = (c == 0); wb_addr = 5'd12; wb_data = 32'h77;
            #1 chk($sformatf("hold%0d_stall", c), {31'd0, b_stall}, 32'd1);
            step();
            chk($sformatf("hold%0d_valid", c), {31'd0, b_valid}, 32'd1);
            chk($sformatf("hold%0d_pc4", c), b_pc4, 32'h500);
            chk($sformatf("hold%0d_ctrl", c), {20'd0, b_ctrl}, 32'h111);
            chk($sformatf("hold%0d_wreg", c), {27'd0, b_wreg}, 32'd13);
        end
        hold = 1'b0; flush = 1'b0; wb_we = 1'b0;
        #1 chk("hold_release_stall", {31'd0, b_stall}, 32'd0);
        step();
        chk("post_hold_valid", {31'd0, b_valid}, 32'd1);
        chk("post_hold_pc4", b_pc4, 32'h504);
        chk("post_hold_ctrl", {20'd0, b_ctrl}, 32'h222);
        chk("post_hold_wreg", {27'd0, b_wreg}, 32'd14);
        chk("post_hold_wb_r12", b_rd1, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
